// File: rtl/stb_rv_pkg.sv
// Shared definitions for the round-robin read arbiter: FSM state type,
// default geometry and the channel-index width helper.
package stb_rv_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_SEND = 1'b1
  } arb_state_t;

  localparam int DEF_NUM_CH     = 4;
  localparam int DEF_DATA_WIDTH = 8;

  // Width of a channel index; never narrower than one bit.
  function automatic int ch_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: rotate the request mask so the search
// starts at ptr, take the lowest set bit, then map the offset back to a
// channel index. ptr is assumed to be below NUM_CH.
module rr_pick
  import stb_rv_pkg::*;
#(
  parameter int  NUM_CH = DEF_NUM_CH,
  localparam int CH_W   = ch_width(NUM_CH)
) (
  input  logic [NUM_CH-1:0] mask,
  input  logic [CH_W-1:0]   ptr,
  output logic              found,
  output logic [CH_W-1:0]   idx
);

  localparam logic [CH_W:0] NUM_CH_V = (CH_W + 1)'(NUM_CH);

  logic [2*NUM_CH-1:0] doubled;
  logic [NUM_CH-1:0]   rotated;
  logic [CH_W-1:0]     offset;
  logic [CH_W:0]       sum;

  // Rotate right by ptr so bit 0 of rotated is channel ptr.
  assign doubled = {mask, mask} >> ptr;
  assign rotated = doubled[NUM_CH-1:0];

  // Priority-encode the rotated mask and unrotate with a modulo-NUM_CH add.
  always_comb begin
    found  = 1'b0;
    offset = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (!found && rotated[i]) begin
        found  = 1'b1;
        offset = CH_W'(i);
      end
    end
    sum = {1'b0, ptr} + {1'b0, offset};
    if (sum >= NUM_CH_V) begin
      sum = sum - NUM_CH_V;
    end
    idx = sum[CH_W-1:0];
  end

endmodule

// File: rtl/rv_read_arbiter.sv
// Round-robin arbiter that funnels per-channel read data onto a single
// registered ready/valid host port, one word per cycle when back-to-back.
module rv_read_arbiter
  import stb_rv_pkg::*;
#(
  parameter int  NUM_CH     = DEF_NUM_CH,
  parameter int  DATA_WIDTH = DEF_DATA_WIDTH,
  localparam int CH_W       = ch_width(NUM_CH)
) (
  input  logic                         CLK_I,
  input  logic                         RST_NI,
  input  logic [NUM_CH-1:0]            REQ_I,
  input  logic [NUM_CH-1:0]            CH_EN_I,
  input  logic [NUM_CH*DATA_WIDTH-1:0] DATA_I,
  output logic [NUM_CH-1:0]            ACK_O,
  input  logic                         READ_READY_I,
  output logic                         READ_VALID_O,
  output logic [DATA_WIDTH-1:0]        READ_DATA_O,
  output logic [CH_W-1:0]              READ_CH_O
);

  arb_state_t            state;
  logic [CH_W-1:0]       ptr;
  logic [CH_W-1:0]       ptr_next;
  logic [CH_W-1:0]       pick_ptr;
  logic [CH_W-1:0]       pick_idx;
  logic                  pick_found;
  logic [NUM_CH-1:0]     eligible;
  logic [NUM_CH-1:0]     pick_mask;
  logic [NUM_CH-1:0]     held_onehot;
  logic [DATA_WIDTH-1:0] pick_data;
  logic                  handshake;

  assign eligible  = REQ_I & CH_EN_I;
  assign handshake = (state == ARB_SEND) && READ_READY_I;
  assign ptr_next  = (READ_CH_O == CH_W'(NUM_CH - 1)) ? '0 : READ_CH_O + 1'b1;
  assign ACK_O     = handshake ? held_onehot : '0;

  // Decode the held channel index to a one-hot vector.
  always_comb begin
    held_onehot = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      held_onehot[i] = (READ_CH_O == CH_W'(i));
    end
  end

  // While a word is held, the re-arbitration already uses the post-handshake
  // pointer and excludes the channel being consumed, so one picker serves both
  // the idle grant and the back-to-back grant.
  always_comb begin
    if (state == ARB_SEND) begin
      pick_mask = eligible & ~held_onehot;
      pick_ptr  = ptr_next;
    end else begin
      pick_mask = eligible;
      pick_ptr  = ptr;
    end
  end

  rr_pick #(
    .NUM_CH(NUM_CH)
  ) u_pick (
    .mask (pick_mask),
    .ptr  (pick_ptr),
    .found(pick_found),
    .idx  (pick_idx)
  );

  // Select the winning channel's data word.
  always_comb begin
    pick_data = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (pick_idx == CH_W'(i)) begin
        pick_data = DATA_I[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Grant FSM and registered host-side outputs.
  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      state        <= ARB_IDLE;
      ptr          <= '0;
      READ_VALID_O <= 1'b0;
      READ_DATA_O  <= '0;
      READ_CH_O    <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (pick_found) begin
            READ_DATA_O  <= pick_data;
            READ_CH_O    <= pick_idx;
            READ_VALID_O <= 1'b1;
            state        <= ARB_SEND;
          end
        end
        ARB_SEND: begin
          if (READ_READY_I) begin
            ptr <= ptr_next;
            if (pick_found) begin
              READ_DATA_O <= pick_data;
              READ_CH_O   <= pick_idx;
            end else begin
              READ_VALID_O <= 1'b0;
              state        <= ARB_IDLE;
            end
          end
        end
        default: begin
          state        <= ARB_IDLE;
          READ_VALID_O <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv_read_arbiter.sv
// Directed scoreboard bench for rv_read_arbiter (4-channel and 3-channel builds).
module tb_rv_read_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int CW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req, en, ack;
  logic [N*DW-1:0] data;
  logic            ready, valid;
  logic [DW-1:0]   rdata;
  logic [CW-1:0]   rch;

  logic [2:0]      req3, en3, ack3;
  logic [3*DW-1:0] data3;
  logic            ready3, valid3;
  logic [DW-1:0]   rdata3;
  logic [1:0]      rch3;

  always #5 clk = ~clk;

  rv_read_arbiter #(.NUM_CH(N), .DATA_WIDTH(DW)) dut (
    .CLK_I(clk), .RST_NI(rst_n), .REQ_I(req), .CH_EN_I(en), .DATA_I(data),
    .ACK_O(ack), .READ_READY_I(ready), .READ_VALID_O(valid),
    .READ_DATA_O(rdata), .READ_CH_O(rch)
  );

  rv_read_arbiter #(.NUM_CH(3), .DATA_WIDTH(DW)) dut3 (
    .CLK_I(clk), .RST_NI(rst_n), .REQ_I(req3), .CH_EN_I(en3), .DATA_I(data3),
    .ACK_O(ack3), .READ_READY_I(ready3), .READ_VALID_O(valid3),
    .READ_DATA_O(rdata3), .READ_CH_O(rch3)
  );

  typedef struct {
    logic [CW-1:0] ch;
    logic [DW-1:0] d;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic push(input int ch, input logic [DW-1:0] d);
    exp_t e;
    e.ch = CW'(ch);
    e.d  = d;
    sb.push_back(e);
  endtask

  task automatic set_word(input int ch, input logic [DW-1:0] d);
    data[ch*DW +: DW] = d;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, 32'(valid), 32'd0);
    chk({tag, "_ack"},   32'(ack),   32'd0);
    chk({tag, "_data"},  32'(rdata), 32'd0);
    chk({tag, "_ch"},    32'(rch),   32'd0);
  endtask

  // Called at negedge after inputs are driven: checks this cycle's outputs,
  // then advances to the next negedge.
  task automatic cyc();
    exp_t          e;
    logic [N-1:0]  ea;
    #1;
    chk("ack_onehot0", 32'($onehot0(ack)), 32'd1);
    if (valid && ready) begin
      n_chk++;
      assert (sb.size() != 0) else begin
        n_fail++;
        $error("FAIL unexpected_word observed ch=%0d data=0x%0h expected none", rch, rdata);
      end
      if (sb.size() != 0) begin
        e  = sb.pop_front();
        ea = '0;
        ea[e.ch] = 1'b1;
        chk("word_ch",   32'(rch),   32'(e.ch));
        chk("word_data", 32'(rdata), 32'(e.d));
        chk("word_ack",  32'(ack),   32'(ea));
      end
    end else begin
      chk("ack_quiet", 32'(ack), 32'd0);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("reset_pulse");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n  = 1'b0;
    req    = '0;
    en     = '1;
    data   = '0;
    ready  = 1'b0;
    req3   = '0;
    en3    = '1;
    data3  = {8'h22, 8'h21, 8'h20};
    ready3 = 1'b0;

    // Reset state
    @(negedge clk);
    chk_reset_outputs("reset");
    chk("reset_valid3", 32'(valid3), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single request on channel 2, latency one
    req = 4'b0100;
    set_word(2, 8'hA5);
    ready = 1'b1;
    push(2, 8'hA5);
    cyc();
    req = '0;
    cyc();
    #1 chk("single_back_idle", 32'(valid), 32'd0);
    @(negedge clk);

    // All channels requesting, pointer from 0: 0,1,2,3,0
    reset_pulse();
    for (int i = 0; i < N; i++) set_word(i, DW'(8'h10 + i));
    req = 4'b1111;
    push(0, 8'h10); push(1, 8'h11); push(2, 8'h12); push(3, 8'h13); push(0, 8'h10);
    cyc();
    for (int k = 0; k < 4; k++) begin
      chk("b2b_valid", 32'(valid), 32'd1);
      cyc();
    end
    req = '0;
    cyc();
    #1 chk("b2b_drain_idle", 32'(valid), 32'd0);
    @(negedge clk);

    // Backpressure on channel 1 while its data changes
    req   = 4'b0010;
    set_word(1, 8'h3C);
    ready = 1'b0;
    push(1, 8'h3C);
    cyc();
    set_word(1, 8'hFF);
    for (int k = 0; k < 5; k++) begin
      req = (k % 2 == 0) ? 4'b1111 : 4'b0000;
      #1;
      chk("bp_valid", 32'(valid), 32'd1);
      chk("bp_data",  32'(rdata), 32'h3C);
      chk("bp_ch",    32'(rch),   32'd1);
      cyc();
    end
    req   = '0;
    ready = 1'b1;
    cyc();
    #1 chk("bp_back_idle", 32'(valid), 32'd0);
    @(negedge clk);

    // Enable mask 1010: pointer now at 2, so order 3,1,3,1
    for (int i = 0; i < N; i++) set_word(i, DW'(8'h40 + i));
    req = 4'b1111;
    en  = 4'b1010;
    push(3, 8'h43); push(1, 8'h41); push(3, 8'h43); push(1, 8'h41);
    cyc();
    cyc(); cyc(); cyc();
    req = '0;
    cyc();
    en = '1;
    #1 chk("mask_back_idle", 32'(valid), 32'd0);
    @(negedge clk);

    // Reset while channel 3 is held
    req   = 4'b1000;
    set_word(3, 8'h77);
    ready = 1'b0;
    cyc();
    #1;
    chk("rst_mid_held_valid", 32'(valid), 32'd1);
    chk("rst_mid_held_ch",    32'(rch),   32'd3);
    ready = 1'b1;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    push(3, 8'h77);
    cyc();
    req = '0;
    cyc();
    #1 chk("rst_mid_back_idle", 32'(valid), 32'd0);
    @(negedge clk);

    // Three-channel build: order 0,1,2,0,1 and index stays below 3
    reset_pulse();
    req3   = 3'b111;
    ready3 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      logic [2:0] ea3;
      ea3 = '0;
      ea3[k % 3] = 1'b1;
      #1;
      chk("n3_valid", 32'(valid3), 32'd1);
      chk("n3_ch",    32'(rch3),   32'(k % 3));
      chk("n3_data",  32'(rdata3), 32'(8'h20 + (k % 3)));
      chk("n3_ack",   32'(ack3),   32'(ea3));
      chk("n3_range", 32'(rch3 != 2'd3), 32'd1);
      @(posedge clk);
      @(negedge clk);
    end
    req3 = '0;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    #1 chk("n3_idle", 32'(valid3), 32'd0);

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rv_read_arbiter.md
RV_READ_ARBITER -- requirements
Module: rv_read_arbiter

Interface
REQ-001 Parameter NUM_CH, default 4, number of device-side read channels (2..16).
REQ-002 Parameter DATA_WIDTH, default 8, width of each channel's data word.
REQ-003 CLK_I  in  1  single clock; all state updates on its rising edge.
REQ-004 RST_NI  in  1  reset, asynchronous assert and active-low.
REQ-005 REQ_I  in  NUM_CH  per-channel "data pending" (driven by each register's read-valid).
REQ-006 CH_EN_I  in  NUM_CH  per-channel arbitration enable mask.
REQ-007 DATA_I  in  NUM_CH x DATA_WIDTH  per-channel read data.
REQ-008 ACK_O  out  NUM_CH  one-hot, one-cycle pulse: the channel's word was consumed.
REQ-009 READ_READY_I  in  1  host side ready.
REQ-010 READ_VALID_O  out  1  host side valid.
REQ-011 READ_DATA_O  out  DATA_WIDTH  registered word presented to host.
REQ-012 READ_CH_O  out  CH_W  index of the channel owning READ_DATA_O. CH_W = max(1, clog2(NUM_CH)).

Function
REQ-013 Eligible set: E = REQ_I & CH_EN_I.
REQ-014 FSM states: IDLE (no word held), SEND (word held, READ_VALID_O=1).
REQ-015 IDLE, E nonzero -> load winner's DATA_I and index into output registers; go to SEND. READ_VALID_O rises the next cycle (latency 1).
REQ-016 IDLE, E zero -> stay IDLE; outputs hold their last value.
REQ-017 Winner: round-robin. Search starts at pointer PTR and wraps NUM_CH-1 -> 0.
REQ-018 SEND, READ_READY_I=0 -> READ_VALID_O, READ_DATA_O and READ_CH_O stay stable. REQ_I/CH_EN_I/DATA_I changes are ignored.
REQ-019 SEND, READ_READY_I=1 (handshake) -> ACK_O[READ_CH_O]=1 in that same cycle (combinational from state and READ_READY_I). PTR <= (READ_CH_O+1) mod NUM_CH.
REQ-020 On handshake, the arbiter re-arbitrates in the same cycle over E with bit READ_CH_O masked off. If the masked set is nonzero, load the winner and stay in SEND (back-to-back, one word per cycle). Otherwise go to IDLE.
REQ-021 ACK_O is zero outside handshake cycles and never has more than one bit set.
REQ-022 Disabling a channel or dropping its REQ_I while it is granted does not abort the transfer. The held word completes normally.
REQ-023 A channel with REQ_I held high is granted again no sooner than after every other eligible channel has been served once (starvation-free).
REQ-024 Non-power-of-two NUM_CH: PTR and the wrap never produce an index >= NUM_CH.

Reset
REQ-025 While RST_NI=0: state=IDLE, PTR=0, READ_VALID_O=0, ACK_O=0, READ_DATA_O=0, READ_CH_O=0. These values apply immediately (asynchronous).
REQ-026 Reset asserted mid-SEND discards the held word without ACK. The requester keeps REQ_I high and is re-arbitrated after release.
REQ-027 First arbitration is possible in the first clock edge after RST_NI deasserts.

Structure
REQ-028 Shared package stb_rv_pkg holds the FSM state enum (ARB_IDLE, ARB_SEND) and the default NUM_CH/DATA_WIDTH constants.
REQ-029 A single sub-module rr_pick performs the combinational rotate, priority-encode and unrotate. It takes mask and PTR; it returns a found flag and an index. It is instantiated once.
REQ-030 All outputs except ACK_O are driven from flops.

Verification
REQ-031 Single request: REQ_I=0b0100 with DATA_I[2]=0xA5, READ_READY_I=1 -> READ_VALID_O=1 with 0xA5 and CH=2 one cycle later. ACK_O=0b0100 in that cycle; then IDLE.
REQ-032 All four channels request continuously, ready=1, PTR=0 -> grant order 0,1,2,3,0 at one word per cycle. Exactly one ACK bit per cycle.
REQ-033 Backpressure: word from ch1 (0x3C) with ready=0 for 5 cycles while DATA_I[1] changes to 0xFF -> output stays 0x3C/CH1. One ACK is issued on the ready cycle.
REQ-034 Mask: REQ_I=0b1111, CH_EN_I=0b1010 -> only channels 1 and 3 are served, alternating. Channels 0 and 2 get no ACK.
REQ-035 Reset mid-SEND: assert RST_NI=0 while ch3 is held -> READ_VALID_O=0 in the same cycle with no ACK. After release, ch3 is granted first (PTR=0 and it is the only requester).
REQ-036 NUM_CH=3 build: continuous requests produce order 0,1,2,0. READ_CH_O never equals 3.
